inst_fetch: RTL

Instruction fetch unit. Owns the program counter, issues word fetches on the instruction bus, buffers returned instructions in a small prefetch FIFO, and presents one instruction per cycle with its address to the if_id pipeline register. It handles jump redirects from execute and back-pressure (hold) from the pipeline, discarding any in-flight fetch made stale by a redirect.

---
 rtl/inst_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, instruction bus requests, prefetch FIFO, jump redirect.
// Optional FETCH_BYPASS_EN: forward a response straight to the outputs when the FIFO is empty.
module inst_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        S_RUN,
        S_DISCARD
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     pc_q;
    logic [31:0]     push_addr_q;
    logic            outstanding_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   level;
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic [31:0]     fifo_addr [FIFO_DEPTH];

    logic            grant;
    logic            resp_run;
    logic            push;
    logic            pop;
    logic            byp;
    logic            head_valid;
    logic [31:0]     head_inst;
    logic [31:0]     head_addr;
    logic            unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // Requests stop once every FIFO slot is either filled or reserved by the fetch in flight.
    assign level       = count_q + CW'(outstanding_q);
    assign ibus_req_o  = !rst_i && (state_q == S_RUN) && !jump_enable_i
                         && (level < CW'(FIFO_DEPTH));
    assign ibus_addr_o = rst_i ? RESET_ADDR : pc_q;
    assign grant       = ibus_req_o && ibus_gnt_i;
    assign resp_run    = !rst_i && (state_q == S_RUN) && ibus_rvalid_i && !jump_enable_i;

    always_comb begin
        head_inst  = fifo_inst[rd_ptr_q];
        head_addr  = fifo_addr[rd_ptr_q];
        head_valid = (count_q != '0);
        byp        = 1'b0;
`ifdef FETCH_BYPASS_EN
        if ((count_q == '0) && resp_run) begin
            head_inst  = ibus_rdata_i;
            head_addr  = push_addr_q;
            head_valid = 1'b1;
            byp        = 1'b1;
        end
`endif
        inst_valid_o = head_valid && !jump_enable_i && !rst_i;
        inst_o       = inst_valid_o ? head_inst : 32'h0;
        inst_addr_o  = inst_valid_o ? head_addr : 32'h0;
    end

    // A bypassed response that is consumed on the spot never touches the FIFO.
    assign pop     = inst_valid_o && !hold_i && !byp;
    assign push    = resp_run && !(byp && !hold_i);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        if (jump_enable_i) begin
            state_d = (outstanding_q && !ibus_rvalid_i) ? S_DISCARD : S_RUN;
        end else if ((state_q == S_DISCARD) && ibus_rvalid_i) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_ADDR;
            push_addr_q   <= RESET_ADDR;
            outstanding_q <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q <= state_d;
            if (jump_enable_i) begin
                pc_q          <= {jump_addr_i[31:2], 2'b00};
                outstanding_q <= (state_d == S_DISCARD);
                rd_ptr_q      <= '0;
                wr_ptr_q      <= '0;
                count_q       <= '0;
            end else if (state_q == S_DISCARD) begin
                if (ibus_rvalid_i) begin
                    outstanding_q <= 1'b0;
                end
            end else begin
                if (grant) begin
                    pc_q          <= pc_q + 32'd4;
                    push_addr_q   <= pc_q;
                    outstanding_q <= 1'b1;
                end else if (ibus_rvalid_i) begin
                    outstanding_q <= 1'b0;
                end
                if (push) begin
                    fifo_addr[wr_ptr_q] <= push_addr_q;
                    fifo_inst[wr_ptr_q] <= ibus_rdata_i;
                    wr_ptr_q            <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_d;
            end
        end
    end

endmodule
